// File: rtl/div_sqrt_arbiter_tp_pkg.sv
// Shared definitions for the div/sqrt arbiter and the iterative unit.
// Holds unit operand widths, round-bit width and the arbiter FSM states.
package fpu_defs_div_sqrt_tp;

    localparam int C_DIV_MANT     = 52;
    localparam int C_DIV_EXP      = 11;
    localparam int C_DIV_PC       = 6;
    localparam int C_DIV_RND_BITS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/div_sqrt_arbiter_tp_if.sv
// Bundle of requester and unit-side signals around the div/sqrt arbiter.
// slave: arbiter view; master: requesters plus the unit (bench view).
interface div_sqrt_arbiter_tp_if #(
    parameter int NUM_REQ = 2
) ();
    import fpu_defs_div_sqrt_tp::*;

    logic [NUM_REQ-1:0]                 Req_valid_SI;
    logic [NUM_REQ-1:0]                 Req_ready_SO;
    logic [NUM_REQ-1:0]                 Req_op_SI;
    logic [NUM_REQ-1:0][C_DIV_PC-1:0]   Req_prec_DI;
    logic [NUM_REQ-1:0][C_DIV_MANT:0]   Req_mant_a_DI;
    logic [NUM_REQ-1:0][C_DIV_MANT:0]   Req_mant_b_DI;
    logic [NUM_REQ-1:0][C_DIV_EXP:0]    Req_exp_a_DI;
    logic [NUM_REQ-1:0][C_DIV_EXP:0]    Req_exp_b_DI;

    logic [NUM_REQ-1:0]                 Resp_valid_SO;
    logic [NUM_REQ-1:0]                 Resp_ready_SI;
    logic [C_DIV_MANT:0]                Resp_mant_DO;
    logic [C_DIV_EXP+1:0]               Resp_exp_DO;
    logic [C_DIV_RND_BITS-1:0]          Resp_round_DO;
    logic                               Resp_err_SO;

    logic                               Unit_div_start_SO;
    logic                               Unit_sqrt_start_SO;
    logic                               Unit_start_SO;
    logic [C_DIV_PC-1:0]                Unit_prec_DO;
    logic [C_DIV_MANT:0]                Unit_mant_a_DO;
    logic [C_DIV_MANT:0]                Unit_mant_b_DO;
    logic [C_DIV_EXP:0]                 Unit_exp_a_DO;
    logic [C_DIV_EXP:0]                 Unit_exp_b_DO;
    logic                               Unit_ready_SI;
    logic                               Unit_done_SI;
    logic [C_DIV_MANT:0]                Unit_mant_DI;
    logic [C_DIV_EXP+1:0]               Unit_exp_DI;
    logic [C_DIV_RND_BITS-1:0]          Unit_round_DI;

    modport slave (
        input  Req_valid_SI, Req_op_SI, Req_prec_DI,
        input  Req_mant_a_DI, Req_mant_b_DI,
        input  Req_exp_a_DI, Req_exp_b_DI,
        output Req_ready_SO,
        output Resp_valid_SO, Resp_mant_DO, Resp_exp_DO,
        output Resp_round_DO, Resp_err_SO,
        input  Resp_ready_SI,
        output Unit_div_start_SO, Unit_sqrt_start_SO, Unit_start_SO,
        output Unit_prec_DO, Unit_mant_a_DO, Unit_mant_b_DO,
        output Unit_exp_a_DO, Unit_exp_b_DO,
        input  Unit_ready_SI, Unit_done_SI,
        input  Unit_mant_DI, Unit_exp_DI, Unit_round_DI
    );

    modport master (
        output Req_valid_SI, Req_op_SI, Req_prec_DI,
        output Req_mant_a_DI, Req_mant_b_DI,
        output Req_exp_a_DI, Req_exp_b_DI,
        input  Req_ready_SO,
        input  Resp_valid_SO, Resp_mant_DO, Resp_exp_DO,
        input  Resp_round_DO, Resp_err_SO,
        output Resp_ready_SI,
        input  Unit_div_start_SO, Unit_sqrt_start_SO, Unit_start_SO,
        input  Unit_prec_DO, Unit_mant_a_DO, Unit_mant_b_DO,
        input  Unit_exp_a_DO, Unit_exp_b_DO,
        output Unit_ready_SI, Unit_done_SI,
        output Unit_mant_DI, Unit_exp_DI, Unit_round_DI
    );

endinterface

// File: rtl/div_sqrt_arbiter_tp_rr.sv
// Round-robin search: first valid requester at or above ptr, with wrap.
// Ports: valid vector, ptr in; one-hot grant, grant index, any out.
module rr_arbiter_tp #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = IW'((int'(ptr) + i) % NUM_REQ);
            if (!any && valid[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/div_sqrt_arbiter_tp.sv
// Shares one iterative div/sqrt unit between NUM_REQ requesters.
// Ports: Clk_CI, Rst_RI (sync, active high), bus (slave modport).
// Optional DIV_SQRT_ARB_TIMEOUT_EN: BUSY watchdog of TIMEOUT_CYC cycles.
module div_sqrt_arbiter_tp #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    div_sqrt_arbiter_tp_if.slave bus
);
    import fpu_defs_div_sqrt_tp::*;

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("div_sqrt_arbiter_tp: parameter out of range");
    end

    arb_state_t state_q, state_d;

    logic [IW-1:0]             rr_ptr_q, owner_q, gnt_idx;
    logic [NUM_REQ-1:0]        gnt_oh, resp_valid;
    logic                      gnt_any;
    logic                      accept, start, capture, resp_hs;

    logic                      op_q;
    logic [C_DIV_PC-1:0]       prec_q;
    logic [C_DIV_MANT:0]       mant_a_q, mant_b_q, res_mant_q;
    logic [C_DIV_EXP:0]        exp_a_q, exp_b_q;
    logic [C_DIV_EXP+1:0]      res_exp_q;
    logic [C_DIV_RND_BITS-1:0] res_round_q;

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout;
    logic          err_q;
`endif

    rr_arbiter_tp #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .valid (bus.Req_valid_SI),
        .ptr   (rr_ptr_q),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        resp_hs = 1'b0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        timeout = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                // Combinational grant is suppressed while reset is held.
                if (gnt_any && !Rst_RI) begin
                    accept  = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.Unit_ready_SI && !Rst_RI) begin
                    start   = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus.Unit_done_SI) begin
                    capture = 1'b1;
                    state_d = ARB_RESP;
                end
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = ARB_RESP;
                end
`endif
            end
            ARB_RESP: begin
                if (bus.Resp_ready_SI[owner_q]) begin
                    resp_hs = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == ARB_RESP && !Rst_RI) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_q        <= 1'b0;
            prec_q      <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            res_mant_q  <= '0;
            res_exp_q   <= '0;
            res_round_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= gnt_idx;
                op_q     <= bus.Req_op_SI[gnt_idx];
                prec_q   <= bus.Req_prec_DI[gnt_idx];
                mant_a_q <= bus.Req_mant_a_DI[gnt_idx];
                mant_b_q <= bus.Req_mant_b_DI[gnt_idx];
                exp_a_q  <= bus.Req_exp_a_DI[gnt_idx];
                exp_b_q  <= bus.Req_exp_b_DI[gnt_idx];
            end
            if (capture) begin
                res_mant_q  <= bus.Unit_mant_DI;
                res_exp_q   <= bus.Unit_exp_DI;
                res_round_q <= bus.Unit_round_DI;
            end
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
            if (timeout) begin
                res_mant_q  <= '0;
                res_exp_q   <= '0;
                res_round_q <= '0;
            end
`endif
            if (resp_hs) begin
                rr_ptr_q <= (owner_q == IW'(NUM_REQ - 1)) ?
                            '0 : owner_q + 1'b1;
            end
        end
    end

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == ARB_BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (resp_hs || capture) begin
                err_q <= 1'b0;
            end
        end
    end
    assign bus.Resp_err_SO = err_q;
`else
    assign bus.Resp_err_SO = 1'b0;
`endif

    assign bus.Req_ready_SO       = accept ? gnt_oh : '0;
    assign bus.Resp_valid_SO      = resp_valid;
    assign bus.Resp_mant_DO       = res_mant_q;
    assign bus.Resp_exp_DO        = res_exp_q;
    assign bus.Resp_round_DO      = res_round_q;
    assign bus.Unit_start_SO      = start;
    assign bus.Unit_div_start_SO  = start & ~op_q;
    assign bus.Unit_sqrt_start_SO = start & op_q;
    assign bus.Unit_prec_DO       = prec_q;
    assign bus.Unit_mant_a_DO     = mant_a_q;
    assign bus.Unit_mant_b_DO     = mant_b_q;
    assign bus.Unit_exp_a_DO      = exp_a_q;
    assign bus.Unit_exp_b_DO      = exp_b_q;

endmodule

// File: tb/tb_div_sqrt_arbiter_tp.sv
// Directed bench for div_sqrt_arbiter_tp with two requesters.
// The bench plays both requesters and the div/sqrt unit.
module tb_div_sqrt_arbiter_tp;
    import fpu_defs_div_sqrt_tp::*;

    typedef struct {
        int          req;
        bit          op;
        logic [63:0] a, b, ea, eb, pc;
        logic [63:0] rm, re, rr;
        logic [1:0]  gnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_sqrt_arbiter_tp_if #(.NUM_REQ(2)) bus ();

    div_sqrt_arbiter_tp #(
        .NUM_REQ     (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Req_valid_SI  = '0;
        bus.Req_op_SI     = '0;
        bus.Req_prec_DI   = '0;
        bus.Req_mant_a_DI = '0;
        bus.Req_mant_b_DI = '0;
        bus.Req_exp_a_DI  = '0;
        bus.Req_exp_b_DI  = '0;
        bus.Resp_ready_SI = '0;
        bus.Unit_ready_SI = 1'b1;
        bus.Unit_done_SI  = 1'b0;
        bus.Unit_mant_DI  = '0;
        bus.Unit_exp_DI   = '0;
        bus.Unit_round_DI = '0;
    endtask

    task automatic drive_req(vec_t v);
        bus.Req_valid_SI[v.req]  = 1'b1;
        bus.Req_op_SI[v.req]     = v.op;
        bus.Req_prec_DI[v.req]   = C_DIV_PC'(v.pc);
        bus.Req_mant_a_DI[v.req] = v.a[C_DIV_MANT:0];
        bus.Req_mant_b_DI[v.req] = v.b[C_DIV_MANT:0];
        bus.Req_exp_a_DI[v.req]  = v.ea[C_DIV_EXP:0];
        bus.Req_exp_b_DI[v.req]  = v.eb[C_DIV_EXP:0];
    endtask

    task automatic accept(vec_t v, logic [1:0] gnt);
        drive_req(v);
        #1;
        chk("req_ready", bus.Req_ready_SO, gnt);
        step();
        bus.Req_valid_SI[v.req] = 1'b0;
    endtask

    task automatic issue(vec_t v);
        #1;
        chk("start", bus.Unit_start_SO, 1);
        chk("div_start", bus.Unit_div_start_SO, !v.op);
        chk("sqrt_start", bus.Unit_sqrt_start_SO, v.op);
        chk("op_mant_a", bus.Unit_mant_a_DO, v.a[C_DIV_MANT:0]);
        chk("op_mant_b", bus.Unit_mant_b_DO, v.b[C_DIV_MANT:0]);
        chk("op_exp_a", bus.Unit_exp_a_DO, v.ea[C_DIV_EXP:0]);
        chk("op_exp_b", bus.Unit_exp_b_DO, v.eb[C_DIV_EXP:0]);
        chk("op_prec", bus.Unit_prec_DO, v.pc[C_DIV_PC-1:0]);
        step();
    endtask

    task automatic unit_done(vec_t v);
        #1;
        chk("busy_no_start", bus.Unit_start_SO, 0);
        bus.Unit_done_SI  = 1'b1;
        bus.Unit_mant_DI  = v.rm[C_DIV_MANT:0];
        bus.Unit_exp_DI   = v.re[C_DIV_EXP+1:0];
        bus.Unit_round_DI = v.rr[3:0];
        step();
        // Scramble the unit outputs to prove the result is buffered.
        bus.Unit_done_SI  = 1'b0;
        bus.Unit_mant_DI  = ~v.rm[C_DIV_MANT:0];
        bus.Unit_exp_DI   = ~v.re[C_DIV_EXP+1:0];
        bus.Unit_round_DI = ~v.rr[3:0];
        #1;
    endtask

    task automatic resp(vec_t v);
        chk("resp_valid", bus.Resp_valid_SO, v.gnt);
        chk("resp_mant", bus.Resp_mant_DO, v.rm[C_DIV_MANT:0]);
        chk("resp_exp", bus.Resp_exp_DO, v.re[C_DIV_EXP+1:0]);
        chk("resp_round", bus.Resp_round_DO, v.rr[3:0]);
        chk("resp_err", bus.Resp_err_SO, 0);
    endtask

    task automatic release_resp(vec_t v);
        bus.Resp_ready_SI[v.req] = 1'b1;
        step();
        bus.Resp_ready_SI[v.req] = 1'b0;
        #1;
        chk("resp_done", bus.Resp_valid_SO, 0);
    endtask

    task automatic run_txn(vec_t v);
        accept(v, v.gnt);
        issue(v);
        unit_done(v);
        resp(v);
        release_resp(v);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{0, 1'b0, 64'h180_0000, 64'h100_0000, 64'h3ff, 64'h3ff,
                   64'h35, 64'h180_0000, 64'h3ff, 64'h0, 2'b01};
        tbl[1] = '{1, 1'b1, 64'h1C0_0000, 64'h1234, 64'h400, 64'h7,
                   64'h18, 64'h150_0000, 64'h200, 64'hA, 2'b10};
        tbl[2] = '{0, 1'b1, 64'h1F_FFFF_FFFF_FFFF, 64'h0, 64'h7FF, 64'h7FF,
                   64'h3F, 64'h1F_FFFF_FFFF_FFFF, 64'h1FFF, 64'hF, 2'b01};
        tbl[3] = '{1, 1'b0, 64'h10_0000_0000_0000, 64'h1F_FFFF_FFFF_FFFF,
                   64'h0, 64'h7FF, 64'h0, 64'h0, 64'h0, 64'h0, 2'b10};

        idle_inputs();
        rst = 1'b1;
        bus.Req_valid_SI = 2'b11;
        step();
        step();
        chk("rst_req_ready", bus.Req_ready_SO, 0);
        chk("rst_resp_valid", bus.Resp_valid_SO, 0);
        chk("rst_start", {bus.Unit_start_SO, bus.Unit_div_start_SO,
                          bus.Unit_sqrt_start_SO}, 0);
        chk("rst_mant_a", bus.Unit_mant_a_DO, 0);
        chk("rst_exp_b", bus.Unit_exp_b_DO, 0);
        chk("rst_resp_mant", bus.Resp_mant_DO, 0);
        chk("rst_err", bus.Resp_err_SO, 0);
        bus.Req_valid_SI = 2'b00;
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i]);
        end

        // Both valid with rr_ptr = 0: req0 then req1.
        drive_req(tbl[1]);
        accept(tbl[0], 2'b01);
        issue(tbl[0]);
        unit_done(tbl[0]);
        chk("owner_busy_ready", bus.Req_ready_SO, 0);
        resp(tbl[0]);
        release_resp(tbl[0]);
        accept(tbl[1], 2'b10);
        issue(tbl[1]);
        unit_done(tbl[1]);
        resp(tbl[1]);
        release_resp(tbl[1]);

        // req0 alone moves rr_ptr to 1; then both valid: req1 first.
        run_txn(tbl[0]);
        drive_req(tbl[0]);
        accept(tbl[1], 2'b10);
        issue(tbl[1]);
        unit_done(tbl[1]);
        resp(tbl[1]);
        release_resp(tbl[1]);
        accept(tbl[0], 2'b01);
        issue(tbl[0]);
        unit_done(tbl[0]);
        resp(tbl[0]);
        release_resp(tbl[0]);

        // Owner stalls the result for 10 cycles.
        accept(tbl[2], 2'b01);
        issue(tbl[2]);
        unit_done(tbl[2]);
        drive_req(tbl[2]);
        drive_req(tbl[3]);
        bus.Resp_ready_SI[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hold_valid", bus.Resp_valid_SO, 2'b01);
            chk("hold_mant", bus.Resp_mant_DO, tbl[2].rm[C_DIV_MANT:0]);
            chk("hold_round", bus.Resp_round_DO, tbl[2].rr[3:0]);
            chk("hold_no_grant", bus.Req_ready_SO, 0);
            step();
        end
        bus.Resp_ready_SI[1] = 1'b0;
        release_resp(tbl[2]);
        chk("b2b_grant", bus.Req_ready_SO, 2'b10);
        bus.Req_valid_SI[0] = 1'b0;
        accept(tbl[3], 2'b10);
        issue(tbl[3]);
        unit_done(tbl[3]);
        resp(tbl[3]);
        release_resp(tbl[3]);

        // Spurious done in IDLE, then unit not ready for 5 cycles.
        bus.Unit_done_SI = 1'b1;
        step();
        bus.Unit_done_SI = 1'b0;
        #1;
        chk("idle_done_ignored", bus.Resp_valid_SO, 0);
        accept(tbl[0], 2'b01);
        bus.Unit_ready_SI = 1'b0;
        bus.Unit_done_SI  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wait_no_start", {bus.Unit_start_SO, bus.Unit_div_start_SO,
                                  bus.Unit_sqrt_start_SO}, 0);
            chk("wait_no_resp", bus.Resp_valid_SO, 0);
            step();
        end
        bus.Unit_done_SI  = 1'b0;
        bus.Unit_ready_SI = 1'b1;
        issue(tbl[0]);
        unit_done(tbl[0]);
        resp(tbl[0]);
        release_resp(tbl[0]);

        // Reset during BUSY followed by a late done.
        accept(tbl[1], 2'b10);
        issue(tbl[1]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.Unit_done_SI = 1'b1;
        step();
        bus.Unit_done_SI = 1'b0;
        #1;
        chk("rst_busy_valid", bus.Resp_valid_SO, 0);
        chk("rst_busy_mant_a", bus.Unit_mant_a_DO, 0);
        chk("rst_busy_resp_mant", bus.Resp_mant_DO, 0);
        chk("rst_busy_start", bus.Unit_start_SO, 0);
        step();
        chk("late_done_valid", bus.Resp_valid_SO, 0);
        run_txn(tbl[1]);

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        accept(tbl[0], 2'b01);
        issue(tbl[0]);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_wait_valid", bus.Resp_valid_SO, 0);
            step();
        end
        chk("to_valid", bus.Resp_valid_SO, 2'b01);
        chk("to_err", bus.Resp_err_SO, 1);
        chk("to_mant", bus.Resp_mant_DO, 0);
        chk("to_exp", bus.Resp_exp_DO, 0);
        chk("to_round", bus.Resp_round_DO, 0);
        release_resp(tbl[0]);
        chk("to_err_clear", bus.Resp_err_SO, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/div_sqrt_arbiter_tp.md
Name: div_sqrt_arbiter_tp

Overview:
- Shares one iterative div/sqrt unit (nrbd_nrsc_tp) between NUM_REQ requesters, e.g. two issue ports or two cores.
- Per requester: valid/ready request handshake plus a per-requester result handshake.
- Round-robin arbitration; operands are latched; unit start pulses are sequenced; the result is buffered until the owner takes it.
- Sits between the FPU issue logic and the div/sqrt unit; the unit has exactly one outstanding operation at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  synchronous active-high reset
- Req_valid_SI  in  NUM_REQ  request valid per requester
- Req_ready_SO  out  NUM_REQ  request accepted (one-hot pulse)
- Req_op_SI  in  NUM_REQ  0 = div, 1 = sqrt
- Req_prec_DI  in  NUM_REQ x C_DIV_PC  precision control
- Req_mant_a_DI  in  NUM_REQ x (C_DIV_MANT+1)  mantissa A
- Req_mant_b_DI  in  NUM_REQ x (C_DIV_MANT+1)  mantissa B (ignored for sqrt)
- Req_exp_a_DI  in  NUM_REQ x (C_DIV_EXP+1)  exponent A
- Req_exp_b_DI  in  NUM_REQ x (C_DIV_EXP+1)  exponent B
- Resp_valid_SO  out  NUM_REQ  result valid, one-hot to the owner
- Resp_ready_SI  in  NUM_REQ  owner takes the result
- Resp_mant_DO  out  C_DIV_MANT+1  buffered mantissa
- Resp_exp_DO  out  C_DIV_EXP+2  buffered exponent
- Resp_round_DO  out  4  buffered round bits
- Resp_err_SO  out  1  timeout flag (0 when the optional feature is off)
- Unit_div_start_SO, Unit_sqrt_start_SO, Unit_start_SO  out  1 each  unit start pulses
- Unit_prec_DO, Unit_mant_a_DO, Unit_mant_b_DO, Unit_exp_a_DO, Unit_exp_b_DO  out  widths as the unit inputs  latched operands
- Unit_ready_SI, Unit_done_SI  in  1 each  unit Ready_SO / Done_SO
- Unit_mant_DI, Unit_exp_DI, Unit_round_DI  in  unit result widths  unit outputs

Behaviour:
- FSM states: IDLE, ISSUE, BUSY, RESP.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: Req_ready_SO, Resp_valid_SO, start pulses, operand registers, result registers, Resp_err_SO.
- IDLE:
  - Grant the first requester with valid set, searching from rr_ptr upward with wrap.
  - Req_ready_SO = one-hot grant, combinational, in the same cycle.
  - Latch op, precision, operands and owner id; next state ISSUE.
  - No requests: stay in IDLE.
- ISSUE:
  - Wait while Unit_ready_SI = 0.
  - When Unit_ready_SI = 1, pulse Unit_start_SO plus Unit_div_start_SO or Unit_sqrt_start_SO for exactly one cycle; next state BUSY.
  - Operand outputs stay stable from ISSUE until RESP exits.
- BUSY: on Unit_done_SI, capture mant/exp/round into the result registers; next state RESP.
- RESP:
  - Resp_valid_SO[owner] = 1 and the result is held stable until Resp_ready_SI[owner] = 1.
  - On that handshake: rr_ptr = (owner+1) mod NUM_REQ; next state IDLE.
- Latency: request accept at cycle t → start pulse no earlier than t+1 → result valid on the cycle after Done.
- Back-to-back requests: a new grant is possible in the cycle after the RESP handshake.
- Unit_done_SI outside BUSY is ignored.
- Resp_ready_SI from a non-owner is ignored.
- Req_valid from the owner during ISSUE/BUSY/RESP is not accepted (ready stays 0).
- Reset mid-operation: FSM returns to IDLE; a late Done is ignored. The integration ties the unit reset to the same source.
- Sqrt: Unit_mant_b_DO and Unit_exp_b_DO are driven with the latched B values unmodified.

Optional Feature:
- Macro: DIV_SQRT_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - Reaching TIMEOUT_CYC without Done forces RESP with the result registers zeroed and Resp_err_SO = 1.
  - Resp_err_SO is held through RESP and cleared on exit.
- Disabled: no counter; Resp_err_SO is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package fpu_defs_div_sqrt_tp:
  - Add an FSM state enum arb_state_t.
  - Add constant C_DIV_RND_BITS = 4.
  - Existing C_DIV_MANT, C_DIV_EXP and C_DIV_PC are reused unchanged.
- Sub-module rr_arbiter_tp: parametric round-robin pointer search; inputs valid vector and rr_ptr; outputs one-hot grant and index.

Test Plan:
- Single div, req0, mant_a = 0x1800000, mant_b = 0x1000000 → one Unit_div_start_SO pulse; Resp_valid_SO = 01 after Done; result equals the unit output.
- Req0 and req1 valid in the same cycle with rr_ptr = 0 → req0 served first, then req1; then with rr_ptr = 1 and both valid again → req1 first.
- Owner holds Resp_ready_SI = 0 for 10 cycles → Resp_valid_SO and result stable; no new Req_ready_SO pulse until the handshake.
- Unit_ready_SI = 0 for 5 cycles in ISSUE → no start pulse during the wait; a single pulse in the cycle Unit_ready_SI rises.
- Rst_RI asserted during BUSY, then a spurious Unit_done_SI → IDLE, all outputs 0, no Resp_valid_SO.
- With DIV_SQRT_ARB_TIMEOUT_EN, TIMEOUT_CYC = 8, Done withheld → RESP after 8 BUSY cycles with Resp_err_SO = 1 and result 0.
